// File: rtl/sdrc_init_pkg.sv
// Shared types and helpers for the SDRAM power-up init sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sdrc_init_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        PRE,
        WAIT_RP,
        AREF,
        WAIT_RFC,
        MRS,
        WAIT_MRD,
        DONE
    } init_state_e;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_PRE  = 3'b010;
    localparam logic [2:0] CMD_AREF = 3'b001;
    localparam logic [2:0] CMD_MRS  = 3'b000;

    // Address bit that selects "all banks" on PRECHARGE.
    localparam int PRE_ALL_BIT = 10;

    // A programmed wait of 0 cycles is treated as 1 cycle.
    function automatic logic [3:0] max1(input logic [3:0] cfg);
        return (cfg == 4'd0) ? 4'd1 : cfg;
    endfunction

endpackage

// File: rtl/sdr_init_seq_timer.sv
// Loadable 16-bit down-counter with a zero flag, saturating at zero.
// Latency: load/decrement visible on the cycle after the clock edge.
// Backpressure: none; load has priority over decrement.
module sdr_init_timer #(
    parameter logic [15:0] RST_VAL = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic        zero
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 16'd0)) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/sdr_init_seq.sv
// SDRAM power-up sequencer: CKE, NOP hold, PRECHARGE ALL, N x AREF, MRS, done.
// Latency: all outputs registered; each command is max(cfg,1) cycles after the last.
// Backpressure: none; owns the command bus until sdr_init_done.
module sdr_init_seq
    import sdrc_init_pkg::*;
#(
    parameter int SDR_ADDR_W   = 13,
    parameter int SDR_BA_W     = 2,
    parameter int INIT_NOP_CYC = 500,
    parameter int REFRESH_CNT  = 2,
    parameter int TMRD_CYC     = 2
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_resetn,
    input  logic [3:0]            cfg_sdr_trp_d,
    input  logic [3:0]            cfg_sdr_trcar_d,
    input  logic [SDR_ADDR_W-1:0] cfg_sdr_mode_reg,
    input  logic                  cfg_init_req,
    output logic                  sdr_cke,
    output logic                  sdr_cs_n,
    output logic                  sdr_ras_n,
    output logic                  sdr_cas_n,
    output logic                  sdr_we_n,
    output logic [SDR_BA_W-1:0]   sdr_ba,
    output logic [SDR_ADDR_W-1:0] sdr_addr,
    output logic                  sdr_init_done
);

    localparam logic [15:0] INIT_LD = 16'(INIT_NOP_CYC - 1);
    localparam logic [15:0] TMRD_LD = 16'(TMRD_CYC - 1);
    localparam logic [3:0]  REF_N   = 4'(REFRESH_CNT);

    init_state_e state_q, state_d;
    logic [3:0]  ref_cnt_q, ref_cnt_d;
    logic        tmr_load;
    logic [15:0] tmr_load_val;
    logic        tmr_zero;

    logic                  cke_q, cke_d;
    logic                  cs_n_q, cs_n_d;
    logic [2:0]            cmd_q, cmd_d;
    logic [SDR_BA_W-1:0]   ba_q, ba_d;
    logic [SDR_ADDR_W-1:0] addr_q, addr_d;
    logic                  done_q, done_d;

    // The timer only runs once CKE is up, so the reset period does not count
    // towards the NOP hold. The timer is loaded on the edge that issues a
    // command, so the next command fires on the edge where it reads zero.
    sdr_init_timer #(
        .RST_VAL (INIT_LD)
    ) u_timer (
        .clk      (sdram_clk),
        .rst_n    (sdram_resetn),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (cke_q),
        .zero     (tmr_zero)
    );

    // Next state, refresh count and timer load.
    always_comb begin
        state_d      = state_q;
        ref_cnt_d    = ref_cnt_q;
        tmr_load     = 1'b0;
        tmr_load_val = 16'd0;
        unique case (state_q)
            PWRUP:          if (cke_q && tmr_zero) state_d = PRE;
            PRE, WAIT_RP:   state_d = tmr_zero ? AREF : WAIT_RP;
            AREF, WAIT_RFC: begin
                if (tmr_zero) state_d = (ref_cnt_q < REF_N) ? AREF : MRS;
                else          state_d = WAIT_RFC;
            end
            MRS, WAIT_MRD:  state_d = tmr_zero ? DONE : WAIT_MRD;
            DONE: begin
                // Soft re-init: one PWRUP cycle with an empty timer gives the
                // single NOP gap before PRECHARGE, without the long hold.
                if (cfg_init_req) begin
                    state_d  = PWRUP;
                    tmr_load = 1'b1;
                end
            end
            default:        state_d = PWRUP;
        endcase
        unique case (state_d)
            PRE: begin
                tmr_load     = 1'b1;
                tmr_load_val = 16'(max1(cfg_sdr_trp_d)) - 16'd1;
                ref_cnt_d    = 4'd0;
            end
            AREF: begin
                tmr_load     = 1'b1;
                tmr_load_val = 16'(max1(cfg_sdr_trcar_d)) - 16'd1;
                ref_cnt_d    = ref_cnt_q + 4'd1;
            end
            MRS: begin
                tmr_load     = 1'b1;
                tmr_load_val = TMRD_LD;
            end
            default: ;
        endcase
    end

    // Command bus decode from the state being entered, so the registered pins
    // line up with the state on the same cycle.
    always_comb begin
        cke_d  = 1'b1;
        cs_n_d = 1'b0;
        cmd_d  = CMD_NOP;
        ba_d   = '0;
        addr_d = '0;
        done_d = (state_d == DONE);
        unique case (state_d)
            PRE: begin
                cmd_d               = CMD_PRE;
                addr_d[PRE_ALL_BIT] = 1'b1;
            end
            AREF:    cmd_d = CMD_AREF;
            MRS: begin
                cmd_d  = CMD_MRS;
                addr_d = cfg_sdr_mode_reg;
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_q   <= PWRUP;
            ref_cnt_q <= 4'd0;
            cke_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            cmd_q     <= CMD_NOP;
            ba_q      <= '0;
            addr_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_cnt_d;
            cke_q     <= cke_d;
            cs_n_q    <= cs_n_d;
            cmd_q     <= cmd_d;
            ba_q      <= ba_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
        end
    end

    assign sdr_cke       = cke_q;
    assign sdr_cs_n      = cs_n_q;
    assign sdr_ras_n     = cmd_q[2];
    assign sdr_cas_n     = cmd_q[1];
    assign sdr_we_n      = cmd_q[0];
    assign sdr_ba        = ba_q;
    assign sdr_addr      = addr_q;
    assign sdr_init_done = done_q;

endmodule

// File: tb/tb_sdr_init_seq.sv
// Bench for sdr_init_seq: two instances (default and 4-refresh/short-hold).
// Expected bus per cycle comes from the command timeline of the init sequence.
// No backpressure on the DUT; the bench samples on the falling edge.
module tb_sdr_init_seq;

    logic        clk;
    logic        rst_n;
    logic [3:0]  trp;
    logic [3:0]  trcar;
    logic [12:0] mode;
    logic        req;

    logic        a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_done;
    logic [1:0]  a_ba;
    logic [12:0] a_addr;
    logic        b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_done;
    logic [1:0]  b_ba;
    logic [12:0] b_addr;

    logic [20:0] bus_a, bus_b;
    assign bus_a = {a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_ba, a_addr, a_done};
    assign bus_b = {b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_ba, b_addr, b_done};

    localparam int INIT_A = 500;
    localparam int INIT_B = 20;
    localparam int NREF_A = 2;
    localparam int NREF_B = 4;
    localparam int TMRD   = 2;
    localparam logic [20:0] RST_BUS = {1'b0, 1'b1, 3'b111, 2'b00, 13'h0000, 1'b0};

    int n_checks = 0;
    int n_errors = 0;

    sdr_init_seq dut_a (
        .sdram_clk        (clk),
        .sdram_resetn     (rst_n),
        .cfg_sdr_trp_d    (trp),
        .cfg_sdr_trcar_d  (trcar),
        .cfg_sdr_mode_reg (mode),
        .cfg_init_req     (req),
        .sdr_cke          (a_cke),
        .sdr_cs_n         (a_cs_n),
        .sdr_ras_n        (a_ras_n),
        .sdr_cas_n        (a_cas_n),
        .sdr_we_n         (a_we_n),
        .sdr_ba           (a_ba),
        .sdr_addr         (a_addr),
        .sdr_init_done    (a_done)
    );

    sdr_init_seq #(
        .INIT_NOP_CYC (INIT_B),
        .REFRESH_CNT  (NREF_B)
    ) dut_b (
        .sdram_clk        (clk),
        .sdram_resetn     (rst_n),
        .cfg_sdr_trp_d    (trp),
        .cfg_sdr_trcar_d  (trcar),
        .cfg_sdr_mode_reg (mode),
        .cfg_init_req     (req),
        .sdr_cke          (b_cke),
        .sdr_cs_n         (b_cs_n),
        .sdr_ras_n        (b_ras_n),
        .sdr_cas_n        (b_cas_n),
        .sdr_we_n         (b_we_n),
        .sdr_ba           (b_ba),
        .sdr_addr         (b_addr),
        .sdr_init_done    (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sp(input logic [3:0] cfg);
        return (cfg == 4'd0) ? 1 : int'(cfg);
    endfunction

    // Expected pins at cycle k of a sequence whose PRECHARGE is at t_pre.
    function automatic logic [20:0] exp_bus(input int k, input int t_pre, input int nref,
                                            input int sp_rp, input int sp_rfc,
                                            input logic [12:0] md);
        logic [2:0]  cmd;
        logic [12:0] addr;
        logic        done;
        int          t_mrs;
        cmd   = 3'b111;
        addr  = 13'h0000;
        t_mrs = t_pre + sp_rp + nref * sp_rfc;
        if (k == t_pre) begin
            cmd  = 3'b010;
            addr = 13'h0400;
        end
        for (int i = 0; i < nref; i++) begin
            if (k == t_pre + sp_rp + i * sp_rfc) cmd = 3'b001;
        end
        if (k == t_mrs) begin
            cmd  = 3'b000;
            addr = md;
        end
        done = (k >= t_mrs + TMRD);
        return {1'b1, 1'b0, cmd, 2'b00, addr, done};
    endfunction

    task automatic check(input string tag, input int k, input logic [20:0] obs,
                         input logic [20:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d obs=%h exp=%h", tag, k, obs, exp);
        end
    endtask

    // Hold reset for two cycles, check reset pins, release on a falling edge
    // so the next rising edge is cycle 0.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_a", -1, bus_a, RST_BUS);
        check("rst_b", -1, bus_b, RST_BUS);
        rst_n = 1'b1;
    endtask

    // Check both instances for ncyc cycles; optionally change trp mid-run.
    // req is dropped after the first edge, which is where a re-init samples it.
    task automatic run_seq(input string tag, input int ncyc, input int pre_a, input int pre_b,
                           input logic [3:0] c_trp, input logic [3:0] c_trcar,
                           input logic [12:0] md, input int chg_at, input logic [3:0] chg_trp);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_a"}, k, bus_a, exp_bus(k, pre_a, NREF_A, sp(c_trp), sp(c_trcar), md));
            check({tag, "_b"}, k, bus_b, exp_bus(k, pre_b, NREF_B, sp(c_trp), sp(c_trcar), md));
            if (k == 0) req = 1'b0;
            if (k == chg_at) trp = chg_trp;
        end
    endtask

    // Request a soft re-init from DONE with the given timing config.
    task automatic reinit(input string tag, input logic [3:0] c_trp, input logic [3:0] c_trcar,
                          input logic [12:0] md);
        @(negedge clk);
        trp   = c_trp;
        trcar = c_trcar;
        mode  = md;
        req   = 1'b1;
        run_seq(tag, 100, 1, 1, c_trp, c_trcar, md, -1, 4'd0);
    endtask

    initial begin
        logic [3:0]  r_trp, r_trcar;
        logic [12:0] r_mode;
        rst_n = 1'b0;
        trp   = 4'd3;
        trcar = 4'd7;
        mode  = 13'h033;
        req   = 1'b0;

        // Defaults: PRE@500, AREF@503/510, MRS@517, done@519.
        do_reset();
        run_seq("dflt", 560, INIT_A, INIT_B, 4'd3, 4'd7, 13'h033, -1, 4'd0);

        // Zero waits clamp to one cycle.
        trp   = 4'd0;
        trcar = 4'd0;
        mode  = 13'h1abc;
        do_reset();
        run_seq("zero", 560, INIT_A, INIT_B, 4'd0, 4'd0, 13'h1abc, -1, 4'd0);

        // Reset pulsed at cycle 505 (inside WAIT_RFC), then a full restart.
        trp   = 4'd3;
        trcar = 4'd7;
        mode  = 13'h033;
        do_reset();
        run_seq("pre_rst", 505, INIT_A, INIT_B, 4'd3, 4'd7, 13'h033, -1, 4'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_a", 505, bus_a, RST_BUS);
        check("async_rst_b", 505, bus_b, RST_BUS);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("post_rst", 560, INIT_A, INIT_B, 4'd3, 4'd7, 13'h033, -1, 4'd0);

        // Soft re-init from DONE, trp=2, trcar=3.
        reinit("reinit", 4'd2, 4'd3, 13'h0231);

        // trp raised mid WAIT_RP must not move the first AREF.
        trp   = 4'd3;
        trcar = 4'd7;
        mode  = 13'h033;
        do_reset();
        run_seq("trp_chg", 560, INIT_A, INIT_B, 4'd3, 4'd7, 13'h033, 501, 4'd9);

        // Randomized configs: one full power-up, then several soft re-inits.
        r_trp   = 4'($urandom_range(0, 15));
        r_trcar = 4'($urandom_range(0, 15));
        r_mode  = 13'($urandom);
        trp     = r_trp;
        trcar   = r_trcar;
        mode    = r_mode;
        do_reset();
        run_seq("rnd_full", 560, INIT_A, INIT_B, r_trp, r_trcar, r_mode, -1, 4'd0);
        for (int i = 0; i < 4; i++) begin
            r_trp   = 4'($urandom_range(0, 15));
            r_trcar = 4'($urandom_range(0, 15));
            r_mode  = 13'($urandom);
            reinit("rnd_reinit", r_trp, r_trcar, r_mode);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
